// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_pkg
// Description : Shared constants for the memory-mapped machine timer.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_timer_pkg;

    localparam logic [31:0] TIMER_BASE   = 32'h0200_0000;

    localparam logic [7:0]  TMR_MTIME_LO = 8'h00;
    localparam logic [7:0]  TMR_MTIME_HI = 8'h04;
    localparam logic [7:0]  TMR_CMP_LO   = 8'h08;
    localparam logic [7:0]  TMR_CMP_HI   = 8'h0C;
    localparam logic [7:0]  TMR_CTRL     = 8'h10;
    localparam logic [7:0]  TMR_PRESC    = 8'h14;
    localparam logic [7:0]  TMR_STATUS   = 8'h18;

    localparam int          CTRL_EN      = 0;
    localparam int          CTRL_IE      = 1;

    localparam logic [1:0]  W_BYTE       = 2'b00;
    localparam logic [1:0]  W_HALF       = 2'b01;
    localparam logic [1:0]  W_WORD       = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mmio_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_if
// Description : CPU data-memory port as seen by the timer (master = core).
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_timer_if;
    logic [31:0] adr;
    logic [1:0]  op;
    logic        we;
    logic [31:0] wdin;
    logic [31:0] rdo;
    logic        hit;

    modport master (output adr, op, we, wdin, input rdo, hit);
    modport slave  (input adr, op, we, wdin, output rdo, hit);
endinterface
`default_nettype wire

// File: rtl/mmio_timer_wr_merge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_wr_merge
// Description : Byte-lane merge of right-aligned write data into a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer_wr_merge
    import mmio_timer_pkg::*;
(
    input  wire logic [31:0] old_i,
    input  wire logic [31:0] wdin_i,
    input  wire logic [1:0]  op_i,
    input  wire logic [1:0]  lane_i,
    output logic      [31:0] new_o,
    output logic             ok_o
);

    always_comb begin
        new_o = old_i;
        ok_o  = 1'b0;
        case (op_i)
            W_WORD: begin
                new_o = wdin_i;
                ok_o  = 1'b1;
            end
            W_HALF: begin
                // Odd-byte half accesses are misaligned and dropped.
                if (!lane_i[0]) begin
                    ok_o = 1'b1;
                    if (lane_i[1]) new_o[31:16] = wdin_i[15:0];
                    else           new_o[15:0]  = wdin_i[15:0];
                end
            end
            W_BYTE: begin
                ok_o = 1'b1;
                new_o[{lane_i, 3'b000} +: 8] = wdin_i[7:0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Memory-mapped 64-bit prescaled machine timer with compare irq.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE,
    parameter int          PRESC_W   = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mmio_timer_if.slave bus,
    output logic        irq_timer
);

    localparam logic [5:0] c_IDX_MLO  = TMR_MTIME_LO[7:2];
    localparam logic [5:0] c_IDX_MHI  = TMR_MTIME_HI[7:2];
    localparam logic [5:0] c_IDX_CLO  = TMR_CMP_LO[7:2];
    localparam logic [5:0] c_IDX_CHI  = TMR_CMP_HI[7:2];
    localparam logic [5:0] c_IDX_CTRL = TMR_CTRL[7:2];
    localparam logic [5:0] c_IDX_PRE  = TMR_PRESC[7:2];
    localparam logic [5:0] c_IDX_STAT = TMR_STATUS[7:2];

    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        cmp_q, cmp_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        rdo_q, rdo_d;
    logic               hit_q;
    logic               irq_q, irq_d;

    logic               w_sel;
    logic [5:0]         w_idx;
    logic [31:0]        w_rdval;
    logic [31:0]        w_new;
    logic               w_lane_ok;
    logic               w_wr;
    logic               w_pend;
    logic               w_tick;
    logic               w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_ctrl, w_wr_pre;

    assign w_sel  = (bus.adr[31:8] == BASE_ADDR[31:8]);
    assign w_idx  = bus.adr[7:2];
    assign w_pend = (mtime_q >= cmp_q);
    assign w_tick = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);

    always_comb begin
        w_rdval = 32'h0;
        case (w_idx)
            c_IDX_MLO:  w_rdval = mtime_q[31:0];
            c_IDX_MHI:  w_rdval = mtime_q[63:32];
            c_IDX_CLO:  w_rdval = cmp_q[31:0];
            c_IDX_CHI:  w_rdval = cmp_q[63:32];
            c_IDX_CTRL: w_rdval = {30'h0, ctrl_q};
            c_IDX_PRE:  w_rdval = 32'(presc_q);
            c_IDX_STAT: w_rdval = {31'h0, w_pend};
            default:    w_rdval = 32'h0;
        endcase
    end

    // The read value doubles as the old word for sub-word merges.
    mmio_timer_wr_merge u_wr_merge (
        .old_i  (w_rdval),
        .wdin_i (bus.wdin),
        .op_i   (bus.op),
        .lane_i (bus.adr[1:0]),
        .new_o  (w_new),
        .ok_o   (w_lane_ok)
    );

    assign w_wr      = w_sel && bus.we && w_lane_ok;
    assign w_wr_mlo  = w_wr && (w_idx == c_IDX_MLO);
    assign w_wr_mhi  = w_wr && (w_idx == c_IDX_MHI);
    assign w_wr_clo  = w_wr && (w_idx == c_IDX_CLO);
    assign w_wr_chi  = w_wr && (w_idx == c_IDX_CHI);
    assign w_wr_ctrl = w_wr && (w_idx == c_IDX_CTRL);
    assign w_wr_pre  = w_wr && (w_idx == c_IDX_PRE);

    always_comb begin
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;

        if (w_wr_clo)  cmp_d[31:0]  = w_new;
        if (w_wr_chi)  cmp_d[63:32] = w_new;
        if (w_wr_ctrl) ctrl_d       = w_new[1:0];
        if (w_wr_pre)  presc_d      = w_new[PRESC_W-1:0];

        if (w_wr_pre || w_wr_mlo || w_wr_mhi) begin
            pcnt_d = '0;
        end else if (ctrl_q[CTRL_EN]) begin
            pcnt_d = w_tick ? '0 : pcnt_q + 1'b1;
        end

        // A software write to either half pre-empts the tick; no carry crosses halves.
        if (w_wr_mlo) begin
            mtime_d[31:0] = w_new;
        end else if (w_wr_mhi) begin
            mtime_d[63:32] = w_new;
        end else if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        rdo_d = w_sel ? w_rdval : 32'h0;
        irq_d = ctrl_q[CTRL_IE] && w_pend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= 64'h0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q  <= 2'b00;
            presc_q <= '0;
            pcnt_q  <= '0;
            rdo_q   <= 32'h0;
            hit_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            rdo_q   <= rdo_d;
            hit_q   <= w_sel;
            irq_q   <= irq_d;
        end
    end

    assign bus.rdo   = rdo_q;
    assign bus.hit   = hit_q;
    assign irq_timer = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_timer
// Description : Directed vector bench for mmio_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;

    localparam logic [31:0] c_BASE = 32'h0200_0000;
    localparam logic [31:0] c_IDLE = 32'h0000_0000;
    localparam int          c_NV   = 28;

    typedef struct {
        logic        wr;
        logic [1:0]  op;
        logic [31:0] adr;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_rdo;
    } vec_t;

    logic clk;
    logic rst_n;
    logic irq_timer;

    mmio_timer_if bus ();

    mmio_timer #(
        .BASE_ADDR (c_BASE),
        .PRESC_W   (16)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .irq_timer (irq_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    vec_t vt [c_NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; the access is captured on the next rising edge.
    task automatic access(input logic wr, input logic [1:0] op, input logic [31:0] adr,
                          input logic [31:0] data, output logic [31:0] rdo, output logic hit);
        bus.adr  = adr;
        bus.op   = op;
        bus.we   = wr;
        bus.wdin = data;
        @(negedge clk);
        rdo      = bus.rdo;
        hit      = bus.hit;
        bus.we   = 1'b0;
        bus.adr  = c_IDLE;
        bus.wdin = 32'h0;
    endtask

    task automatic wr_word(input logic [7:0] off, input logic [31:0] data);
        logic [31:0] r;
        logic        h;
        access(1'b1, 2'b10, c_BASE + 32'(off), data, r, h);
    endtask

    task automatic rd_check(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] r;
        logic        h;
        access(1'b0, 2'b10, c_BASE + 32'(off), 32'h0, r, h);
        check(name, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic        h;

        vt[0]  = '{1'b0, 2'b10, c_BASE + 32'h10,  32'h0,         1'b1, 32'h0};
        vt[1]  = '{1'b0, 2'b10, c_BASE + 32'h14,  32'h0,         1'b1, 32'h0};
        vt[2]  = '{1'b0, 2'b10, c_BASE + 32'h08,  32'h0,         1'b1, 32'hFFFF_FFFF};
        vt[3]  = '{1'b0, 2'b10, c_BASE + 32'h0C,  32'h0,         1'b1, 32'hFFFF_FFFF};
        vt[4]  = '{1'b0, 2'b10, c_BASE + 32'h00,  32'h0,         1'b1, 32'h0};
        vt[5]  = '{1'b0, 2'b10, c_BASE + 32'h18,  32'h0,         1'b1, 32'h0};
        vt[6]  = '{1'b0, 2'b10, c_BASE + 32'h108, 32'h0,         1'b0, 32'h0};
        vt[7]  = '{1'b0, 2'b10, c_BASE + 32'h1C,  32'h0,         1'b1, 32'h0};
        vt[8]  = '{1'b1, 2'b10, c_BASE + 32'h08,  32'h0,         1'b1, 32'h0};
        vt[9]  = '{1'b1, 2'b00, c_BASE + 32'h09,  32'h0000_00AB, 1'b1, 32'h0};
        vt[10] = '{1'b0, 2'b10, c_BASE + 32'h08,  32'h0,         1'b1, 32'h0000_AB00};
        vt[11] = '{1'b1, 2'b01, c_BASE + 32'h0B,  32'h0000_1234, 1'b1, 32'h0};
        vt[12] = '{1'b0, 2'b10, c_BASE + 32'h08,  32'h0,         1'b1, 32'h0000_AB00};
        vt[13] = '{1'b1, 2'b11, c_BASE + 32'h08,  32'hFFFF_FFFF, 1'b1, 32'h0};
        vt[14] = '{1'b0, 2'b10, c_BASE + 32'h08,  32'h0,         1'b1, 32'h0000_AB00};
        vt[15] = '{1'b1, 2'b10, c_BASE + 32'h108, 32'h0000_0055, 1'b0, 32'h0};
        vt[16] = '{1'b0, 2'b10, c_BASE + 32'h08,  32'h0,         1'b1, 32'h0000_AB00};
        vt[17] = '{1'b1, 2'b01, c_BASE + 32'h0A,  32'h0000_BEEF, 1'b1, 32'h0};
        vt[18] = '{1'b0, 2'b10, c_BASE + 32'h08,  32'h0,         1'b1, 32'hBEEF_AB00};
        vt[19] = '{1'b1, 2'b00, c_BASE + 32'h0C,  32'h0000_0077, 1'b1, 32'h0};
        vt[20] = '{1'b0, 2'b10, c_BASE + 32'h0C,  32'h0,         1'b1, 32'hFFFF_FF77};
        vt[21] = '{1'b1, 2'b10, c_BASE + 32'h10,  32'hFFFF_FFFE, 1'b1, 32'h0};
        vt[22] = '{1'b0, 2'b10, c_BASE + 32'h10,  32'h0,         1'b1, 32'h0000_0002};
        vt[23] = '{1'b1, 2'b10, c_BASE + 32'h14,  32'hFFFF_1234, 1'b1, 32'h0};
        vt[24] = '{1'b0, 2'b10, c_BASE + 32'h14,  32'h0,         1'b1, 32'h0000_1234};
        vt[25] = '{1'b1, 2'b10, c_BASE + 32'h18,  32'h0000_0001, 1'b1, 32'h0};
        vt[26] = '{1'b0, 2'b10, c_BASE + 32'h18,  32'h0,         1'b1, 32'h0};
        vt[27] = '{1'b1, 2'b10, c_BASE + 32'h10,  32'h0,         1'b1, 32'h0};

        rst_n    = 1'b0;
        bus.adr  = c_IDLE;
        bus.op   = 2'b10;
        bus.we   = 1'b0;
        bus.wdin = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_rdo", bus.rdo, 32'h0);
        check("reset_hit", 32'(bus.hit), 32'h0);
        check("reset_irq", 32'(irq_timer), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < c_NV; i++) begin
            access(vt[i].wr, vt[i].op, vt[i].adr, vt[i].data, r, h);
            check($sformatf("vec%0d_hit", i), 32'(h), 32'(vt[i].exp_hit));
            if (!vt[i].wr) check($sformatf("vec%0d_rdo", i), r, vt[i].exp_rdo);
        end
        check("table_irq", 32'(irq_timer), 32'h0);

        // Prescale by 4 over 40 cycles, then freeze.
        wr_word(8'h14, 32'd3);
        wr_word(8'h00, 32'd0);
        wr_word(8'h04, 32'd0);
        wr_word(8'h10, 32'd1);
        repeat (40) @(negedge clk);
        rd_check("presc_mtime", 8'h00, 32'd10);
        wr_word(8'h10, 32'd0);
        repeat (20) @(negedge clk);
        rd_check("frozen_mtime", 8'h00, 32'd10);

        // Interrupt rises one cycle after mtime reaches CMP.
        wr_word(8'h0C, 32'd0);
        wr_word(8'h08, 32'd5);
        wr_word(8'h14, 32'd0);
        wr_word(8'h00, 32'd0);
        wr_word(8'h10, 32'd3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("irq_low_%0d", k), 32'(irq_timer), 32'h0);
        end
        @(negedge clk);
        check("irq_rise", 32'(irq_timer), 32'h1);
        rd_check("status_pend", 8'h18, 32'h1);
        wr_word(8'h08, 32'd100);
        check("irq_hold", 32'(irq_timer), 32'h1);
        @(negedge clk);
        check("irq_fall", 32'(irq_timer), 32'h0);
        wr_word(8'h10, 32'd0);

        // 64-bit wrap.
        wr_word(8'h04, 32'hFFFF_FFFF);
        wr_word(8'h00, 32'hFFFF_FFFE);
        wr_word(8'h10, 32'd1);
        @(negedge clk);
        wr_word(8'h10, 32'd0);
        rd_check("wrap_hi", 8'h04, 32'h0);
        rd_check("wrap_lo", 8'h00, 32'h0);

        // Write to MTIME_LO on a tick edge: written value wins, no carry.
        wr_word(8'h04, 32'd5);
        wr_word(8'h00, 32'hFFFF_FFFF);
        wr_word(8'h10, 32'd1);
        wr_word(8'h00, 32'h0000_1234);
        rd_check("tickwr_lo", 8'h00, 32'h0000_1234);
        rd_check("tickwr_hi", 8'h04, 32'd5);
        wr_word(8'h10, 32'd0);

        // Asynchronous reset between clock edges.
        wr_word(8'h00, 32'd123);
        wr_word(8'h04, 32'd0);
        wr_word(8'h08, 32'd5);
        wr_word(8'h0C, 32'd0);
        wr_word(8'h10, 32'd2);
        @(negedge clk);
        check("pre_rst_irq", 32'(irq_timer), 32'h1);
        access(1'b0, 2'b10, c_BASE, 32'h0, r, h);
        check("pre_rst_rdo", r, 32'd123);
        check("pre_rst_hit", 32'(h), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdo", bus.rdo, 32'h0);
        check("async_hit", 32'(bus.hit), 32'h0);
        check("async_irq", 32'(irq_timer), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("post_rst_mtime", 8'h00, 32'h0);
        rd_check("post_rst_ctrl", 8'h10, 32'h0);
        rd_check("post_rst_cmp_hi", 8'h0C, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped machine timer that responds on the CPU data-memory port: adr, write op, we, wdin in; rdo out.
- Sits beside dram on that port. The top level muxes rdo from this block or from dram using the registered hit flag.
- Holds a 64-bit prescaled time counter and a 64-bit compare register.
- Drives a level timer-interrupt request into the core's exception/interrupt logic.

Parameters:
- BASE_ADDR, 32'h0200_0000, region base; must be 256-byte aligned; the block decodes adr[31:8].
- PRESC_W, 16, width of the prescaler register and the prescaler counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, asynchronous assert, active-low
- adr  input  32  byte address from the EX stage (same signal as dram_adr)
- op  input  2  write size: 2'b00 byte, 2'b01 half, 2'b10 word (shared defines encoding)
- we  input  1  write enable
- wdin  input  32  write data, right-aligned (byte in [7:0], half in [15:0])
- rdo  output  32  read data, registered, valid the cycle after adr
- hit  output  1  registered: the previous cycle's adr fell in this block's region
- irq_timer  output  1  timer interrupt request, level, registered

Behaviour:
- Decode: sel = (adr[31:8] == BASE_ADDR[31:8]). Register offset = adr[7:2].
- Register map, byte offsets from base:
  - 0x00 MTIME_LO, 0x04 MTIME_HI (RW)
  - 0x08 CMP_LO, 0x0C CMP_HI (RW)
  - 0x10 CTRL (RW): bit0 EN, bit1 IE; other bits read 0
  - 0x14 PRESC (RW): low PRESC_W bits
  - 0x18 STATUS (RO): bit0 PEND = (mtime >= mtimecmp), unsigned 64-bit compare
  - Unmapped offsets: read 0, writes ignored.
- Read timing:
  - rdo <= sel ? reg[offset] : 32'h0 every clock; one-cycle latency, same timing as dram.
  - hit <= sel.
  - Reads have no side effects.
  - Software reads 64-bit time with a HI-LO-HI loop; there is no snapshot register.
- Write rules, applied on the clock edge when sel & we:
  - op=word: all 32 bits written; adr[1:0] ignored.
  - op=half: lane adr[1]; adr[0]=1 is misaligned and the write is dropped.
  - op=byte: lane adr[1:0]. Unselected lanes keep their value.
  - op=2'b11: no write.
- Prescaler:
  - pcnt counts clk cycles while EN=1.
  - tick when pcnt == PRESC; pcnt then returns to 0. PRESC=0 gives a tick every cycle.
  - EN=0 freezes both pcnt and mtime.
  - Any write to PRESC, MTIME_LO or MTIME_HI clears pcnt.
- Counter:
  - On tick, mtime <= mtime + 1; wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - A write to MTIME_LO or MTIME_HI in the same cycle as a tick: the written value wins, no increment, and the untouched half keeps its old value (no carry).
- Interrupt:
  - irq_timer <= IE & (mtime >= mtimecmp), computed from current register values, so it is one cycle late relative to the register change.
  - The only ways to clear it are writing CMP above mtime, writing MTIME below CMP, or clearing IE.
  - PEND is combinational from current registers.
- Reset (async, rst_n=0, any time, including mid-count):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESC=0, pcnt=0
  - rdo=0, hit=0, irq_timer=0
- No FSM beyond the prescaler counter. Single clock domain; no backpressure, so every access completes in one cycle.

Decomposition:
- Shared defines file gains:
  - TIMER_BASE
  - offsets TMR_MTIME_LO/HI, TMR_CMP_LO/HI, TMR_CTRL, TMR_PRESC, TMR_STATUS
  - CTRL bit indices
  - write-op encodings W_BYTE, W_HALF, W_WORD, reused from the dram interface
- One natural sub-module: wr_merge, a combinational byte-lane merge of old value, wdin, op and adr[1:0] into a new 32-bit value. Shared with dram if desired.
- Everything else stays in mmio_timer.

Test Plan:
- Reset defaults: after rst_n release, read 0x10/0x14/0x08/0x0C -> rdo = 0 / 0 / FFFF_FFFF / FFFF_FFFF; irq_timer=0; hit follows adr one cycle late.
- Prescale: PRESC=3, CTRL=1, MTIME=0, run 40 cycles -> MTIME_LO=10. Then set CTRL=0 -> value frozen across 20 cycles.
- Interrupt: CMP_HI=0, CMP_LO=5, PRESC=0, CTRL=3 -> irq_timer rises exactly one cycle after mtime reaches 5. Write CMP_LO=100 -> irq_timer falls one cycle later.
- Wrap: MTIME_HI=FFFF_FFFF, MTIME_LO=FFFF_FFFE, PRESC=0, EN=1 -> after 2 ticks MTIME_HI=0, MTIME_LO=0. Write MTIME_LO during a tick -> written value held, no increment.
- Partial writes:
  - byte 8'hAB to base+0x09 with CMP_LO=0 -> CMP_LO=0000_AB00
  - half at base+0x0B -> ignored
  - op=2'b11 -> ignored
  - address outside region (base+0x100) -> no write, hit=0, rdo=0
- Async reset mid-count: assert rst_n between edges with mtime=123 and irq_timer=1 -> all outputs 0 immediately, before the next clk edge.
